// File: rtl/confreg_responder.sv
// confreg_responder
// Memory-mapped configuration register block answering a data-SRAM style bus
// in the 0xBFAF_xxxx window. Reads have one cycle of latency through a
// registered rdata; writes are byte-enabled and take effect at the request edge.
//
// Ports:
//   clk              system clock, all state on the rising edge
//   resetn           asynchronous active-low reset
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables (0 = read)
//   data_sram_addr   byte address, addr[1:0] ignored
//   data_sram_wdata  write data
//   data_sram_rdata  registered read data
//   switch           asynchronous board switches (synchronised internally)
//   led              LED register contents
//   num_data         seven-segment register contents
//
// Optional feature: define CONFREG_TIMER_EN to build the free-running TIMER
// register at offset E000. Without it that offset reads 0 and ignores writes.

module confreg_responder (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch,
   output logic [15:0] led,
   output logic [31:0] num_data
);

   localparam logic [15:0] BASE_HI      = 16'hBFAF;
   localparam logic [13:0] OFF_LED      = 14'(16'hF000 >> 2);
   localparam logic [13:0] OFF_SWITCH   = 14'(16'hF004 >> 2);
   localparam logic [13:0] OFF_NUM      = 14'(16'hF008 >> 2);
   localparam logic [13:0] OFF_SCRATCH0 = 14'(16'hF00C >> 2);
   localparam logic [13:0] OFF_SCRATCH1 = 14'(16'hF010 >> 2);
   localparam logic [13:0] OFF_CNT      = 14'(16'hF020 >> 2);
   localparam logic [13:0] OFF_TIMER    = 14'(16'hE000 >> 2);

   logic        hit;
   logic        is_write;
   logic [13:0] word_off;
   logic [31:0] wmask;
   logic        sel_led;
   logic        sel_num;
   logic        sel_scratch0;
   logic        sel_scratch1;
   logic        sel_timer;

   logic [15:0] led_reg;
   logic [31:0] num_reg;
   logic [31:0] scratch0_reg;
   logic [31:0] scratch1_reg;
   logic [31:0] access_cnt_reg;
   logic [7:0]  sw_sync1_reg;
   logic [7:0]  sw_sync2_reg;
   logic [31:0] rdata_reg;
   logic [31:0] timer_value;
   logic [31:0] rd_value;

   assign hit      = data_sram_en && (data_sram_addr[31:16] == BASE_HI);
   assign is_write = |data_sram_wen;
   assign word_off = data_sram_addr[15:2];

   // Expand the four byte enables into a 32-bit bit mask for byte merging.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wmask
         assign wmask[8*gi +: 8] = {8{data_sram_wen[gi]}};
      end
   endgenerate

   assign sel_led      = hit && is_write && (word_off == OFF_LED);
   assign sel_num      = hit && is_write && (word_off == OFF_NUM);
   assign sel_scratch0 = hit && is_write && (word_off == OFF_SCRATCH0);
   assign sel_scratch1 = hit && is_write && (word_off == OFF_SCRATCH1);
   assign sel_timer    = hit && is_write && (word_off == OFF_TIMER);

   // Address bits below word granularity carry no information here.
   logic unused_bits;
   assign unused_bits = ^{data_sram_addr[1:0], sel_timer};

`ifdef CONFREG_TIMER_EN
   logic [31:0] timer_reg;

   // A write takes priority over the free-running increment; counting
   // continues from the loaded value on the following edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_reg <= '0;
      end else if (sel_timer) begin
         timer_reg <= (timer_reg & ~wmask) | (data_sram_wdata & wmask);
      end else begin
         timer_reg <= timer_reg + 32'd1;
      end
   end

   assign timer_value = timer_reg;
`else
   assign timer_value = '0;
`endif

   // Read mux over pre-edge register values.
   always_comb begin
      rd_value = '0;
      unique case (word_off)
         OFF_LED:      rd_value = {16'h0, led_reg};
         OFF_SWITCH:   rd_value = {24'h0, sw_sync2_reg};
         OFF_NUM:      rd_value = num_reg;
         OFF_SCRATCH0: rd_value = scratch0_reg;
         OFF_SCRATCH1: rd_value = scratch1_reg;
         OFF_CNT:      rd_value = access_cnt_reg;
         OFF_TIMER:    rd_value = timer_value;
         default:      rd_value = '0;
      endcase
   end

   // Writable registers. LED only has two bytes, so upper enables fall away.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_reg      <= '0;
         num_reg      <= '0;
         scratch0_reg <= '0;
         scratch1_reg <= '0;
      end else begin
         if (sel_led) begin
            led_reg <= (led_reg & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
         end
         if (sel_num) begin
            num_reg <= (num_reg & ~wmask) | (data_sram_wdata & wmask);
         end
         if (sel_scratch0) begin
            scratch0_reg <= (scratch0_reg & ~wmask) | (data_sram_wdata & wmask);
         end
         if (sel_scratch1) begin
            scratch1_reg <= (scratch1_reg & ~wmask) | (data_sram_wdata & wmask);
         end
      end
   end

   // Every hit counts, read or write; a read of this register sees the
   // value from before its own increment because rd_value is pre-edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         access_cnt_reg <= '0;
      end else if (hit) begin
         access_cnt_reg <= access_cnt_reg + 32'd1;
      end
   end

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sw_sync1_reg <= '0;
         sw_sync2_reg <= '0;
      end else begin
         sw_sync1_reg <= switch;
         sw_sync2_reg <= sw_sync1_reg;
      end
   end

   // Read data: hit reads load the register value, any non-hit request
   // returns zero, hit writes and idle cycles leave the previous value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_reg <= '0;
      end else if (data_sram_en) begin
         if (!hit) begin
            rdata_reg <= '0;
         end else if (!is_write) begin
            rdata_reg <= rd_value;
         end
      end
   end

   assign data_sram_rdata = rdata_reg;
   assign led             = led_reg;
   assign num_data        = num_reg;

endmodule

// File: tb/tb_confreg_responder.sv
// tb_confreg_responder
// Directed and randomised stimulus for confreg_responder, checked against a
// behavioural register-map model that is updated once per clock edge.

module tb_confreg_responder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [31:0] num_data;

   always #5 clk = ~clk;

`ifdef CONFREG_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   confreg_responder dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch          (switch),
      .led             (led),
      .num_data        (num_data)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   logic [15:0] m_led;
   logic [31:0] m_num, m_s0, m_s1, m_cnt, m_timer, m_rdata;
   logic [7:0]  m_sw_pipe [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nv[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [15:0] off);
      case (off)
         16'hF000: return {16'h0, m_led};
         16'hF004: return {24'h0, m_sw_pipe[0]};
         16'hF008: return m_num;
         16'hF00C: return m_s0;
         16'hF010: return m_s1;
         16'hF020: return m_cnt;
         16'hE000: return TIMER_EN ? m_timer : 32'h0;
         default:  return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_led = '0; m_num = '0; m_s0 = '0; m_s1 = '0; m_cnt = '0; m_timer = '0; m_rdata = '0;
      m_sw_pipe = '{8'h00, 8'h00};
   endtask

   // One rising edge of the model. m_sw_pipe[0] is the readable (second
   // stage) value, m_sw_pipe[1] the first stage.
   task automatic model_edge(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [7:0] sw);
      logic [15:0] off = {addr[15:2], 2'b00};
      logic        h   = en && (addr[31:16] == 16'hBFAF);
      logic        wr_timer = h && (wen != 0) && (off == 16'hE000);
      logic [31:0] t_pre = m_timer;
      if (en && !h) m_rdata = 32'h0;
      if (h) begin
         if (wen == 0) m_rdata = m_read(off);
         else begin
            case (off)
               16'hF000: m_led = merge({16'h0, m_led}, wdata, wen & 4'b0011) >> 0;
               16'hF008: m_num = merge(m_num, wdata, wen);
               16'hF00C: m_s0  = merge(m_s0, wdata, wen);
               16'hF010: m_s1  = merge(m_s1, wdata, wen);
               default: ;
            endcase
         end
         m_cnt = m_cnt + 1;
      end
      if (TIMER_EN) m_timer = wr_timer ? merge(t_pre, wdata, wen) : t_pre + 1;
      void'(m_sw_pipe.pop_front());
      m_sw_pipe.push_back(sw);
   endtask

   // Drive one bus cycle, advance one edge, compare all outputs to the model.
   task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
      data_sram_en = en; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
      @(posedge clk);
      model_edge(en, wen, addr, wdata, switch);
      #1;
      check({tag, "/rdata"}, data_sram_rdata, m_rdata);
      check({tag, "/led"}, {16'h0, led}, {16'h0, m_led});
      check({tag, "/num"}, num_data, m_num);
      $display("step %-14s en=%0b wen=%04b addr=%08h wdata=%08h rdata=%08h led=%04h num=%08h",
               tag, en, wen, addr, wdata, data_sram_rdata, led, num_data);
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 4'h0, 32'h0, 32'h0, tag);
   endtask

   localparam logic [15:0] OFFS [9] = '{16'hF000, 16'hF004, 16'hF008, 16'hF00C, 16'hF010,
                                        16'hF020, 16'hE000, 16'hF100, 16'hF014};

   initial begin
      logic [31:0] a, d;
      logic [3:0]  w;
      resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = '0;
      data_sram_addr = '0; data_sram_wdata = '0; switch = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset/rdata", data_sram_rdata, 32'h0);
      check("reset/led", {16'h0, led}, 32'h0);
      check("reset/num", num_data, 32'h0);
      resetn = 1'b1;

      // NUM write then read
      step(1'b1, 4'b1111, 32'hBFAFF008, 32'h12345678, "wr_num");
      check("num_direct", num_data, 32'h12345678);
      step(1'b1, 4'b0000, 32'hBFAFF008, 32'h0, "rd_num");
      check("rd_num_const", data_sram_rdata, 32'h12345678);

      // LED partial write, SCRATCH0 single byte
      step(1'b1, 4'b0011, 32'hBFAFF000, 32'hFFFFA5C3, "wr_led");
      check("led_const", {16'h0, led}, 32'h0000A5C3);
      step(1'b1, 4'b0000, 32'hBFAFF000, 32'h0, "rd_led");
      check("rd_led_const", data_sram_rdata, 32'h0000A5C3);
      step(1'b1, 4'b0100, 32'hBFAFF00C, 32'h00AB0000, "wr_s0");
      step(1'b1, 4'b0000, 32'hBFAFF00C, 32'h0, "rd_s0");
      check("rd_s0_const", data_sram_rdata, 32'h00AB0000);

      // Non-hit accesses
      step(1'b1, 4'b1111, 32'h1FAFF008, 32'hDEADBEEF, "nh_wr");
      step(1'b1, 4'b0000, 32'h1FAFF008, 32'h0, "nh_rd");
      check("nh_rd_const", data_sram_rdata, 32'h0);
      check("nh_num_const", num_data, 32'h12345678);
      step(1'b1, 4'b0000, 32'hBFAFF020, 32'h0, "rd_cnt");
      check("cnt_const", data_sram_rdata, 32'd6);

      // Switch synchroniser latency and unmapped read
      switch = 8'h5A;
      idle("sw_n");
      idle("sw_n1");
      step(1'b1, 4'b0000, 32'hBFAFF004, 32'h0, "rd_sw");
      check("sw_const", data_sram_rdata, 32'h0000005A);
      step(1'b1, 4'b0000, 32'hBFAFF100, 32'h0, "rd_unmapped");
      check("unmapped_const", data_sram_rdata, 32'h0);

      // Timer wrap (reads 0 in both builds)
      step(1'b1, 4'b1111, 32'hBFAFE000, 32'hFFFFFFFE, "wr_timer");
      idle("tm_idle0");
      idle("tm_idle1");
      step(1'b1, 4'b0000, 32'hBFAFE000, 32'h0, "rd_timer");
      check("timer_const", data_sram_rdata, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
         a = {($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'hBFAF,
              OFFS[$urandom_range(0, 8)]};
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         d = $urandom;
         step(1'($urandom_range(0, 3) != 0), w, a, d, "rand");
      end

      // Asynchronous reset mid-stream after three hits
      step(1'b1, 4'b1111, 32'hBFAFF008, 32'hCAFEF00D, "pre_rst0");
      step(1'b1, 4'b0011, 32'hBFAFF000, 32'h00001234, "pre_rst1");
      step(1'b1, 4'b0000, 32'hBFAFF008, 32'h0, "pre_rst2");
      data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'hBFAFF020;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check("arst/rdata", data_sram_rdata, 32'h0);
      check("arst/led", {16'h0, led}, 32'h0);
      check("arst/num", num_data, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      step(1'b1, 4'b0000, 32'hBFAFF020, 32'h0, "rd_cnt_post");
      check("cnt_post_rst", data_sram_rdata, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion within time limit");
      $fatal(1, "timeout");
   end

endmodule
